// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and constants for the JTAG UART transmit arbiter family.
//   state_t    : arbiter FSM states (idle / tag byte / packet data)
//   MAX_NREQ   : widest requester vector any arbiter in this family supports
//   ID_W       : width of a requester index
//   CNT_W      : width of the idle-timeout counter
//   TAG_PREFIX : upper nibble of the channel-tag byte
//   tag_byte() : builds the channel-tag byte for a requester index
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    localparam int          MAX_NREQ   = 8;
    localparam int          ID_W       = 3;
    localparam int          CNT_W      = 16;
    localparam logic [3:0]  TAG_PREFIX = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    function automatic logic [7:0] tag_byte(input logic [ID_W-1:0] id);
        return {TAG_PREFIX, 1'b0, id};
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: returns the first set request bit found
// scanning upward from ptr, wrapping past NREQ-1 back to 0.
// Ports:
//   req [NREQ-1:0] : request vector
//   ptr [ID_W-1:0] : index to start the scan from (must be < NREQ)
//   idx [ID_W-1:0] : index of the winning request (0 when none)
//   any            : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [ID_W:0]     sum;

    always_comb begin
        // Rotating a doubled copy right by ptr puts the scan start at bit 0,
        // so the lowest set bit of rot is the round-robin winner.
        dbl = {req, req};
        rot = NREQ'(dbl >> ptr);
        any = 1'b0;
        sum = '0;
        // Scan downward so the lowest set offset is the last one written.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (ID_W+1)'(k);
            end
        end
        idx = (sum >= (ID_W+1)'(NREQ)) ? ID_W'(sum - (ID_W+1)'(NREQ))
                                       : sum[ID_W-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Packet-level round-robin arbiter sharing one JTAG UART TX byte channel
// among NREQ requesters. One requester is granted per packet (framed by
// req_last); an optional channel-tag byte precedes each packet, and bytes leave
// through a registered valid/ready stage. A grantee that stays idle for
// TIMEOUT consecutive cycles loses its grant.
// Ports:
//   clk, rstn            : clock, synchronous active-low reset
//   req_valid/last[NREQ] : per-requester byte valid / end-of-packet flag
//   req_data[8*NREQ]     : requester i on bits [8i+7:8i]
//   req_ready[NREQ]      : per-requester accept, at most one bit set
//   out_valid/out_data   : registered output byte toward the TX FIFO
//   out_ready            : TX FIFO not-full
//   grant_id             : current or most recent grantee
//   busy                 : arbiter is serving a packet
//   timeout_evt          : one-cycle pulse when a grant is revoked by timeout
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255,
    parameter int TAG_EN  = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic [ID_W-1:0]   grant_id,
    output logic              busy,
    output logic              timeout_evt
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t                  state;
    logic [ID_W-1:0]         rr_ptr;
    logic [CNT_W-1:0]        idle_cnt;

    logic [MAX_NREQ-1:0]     valid_ext;
    logic [MAX_NREQ-1:0]     last_ext;
    logic [8*MAX_NREQ-1:0]   data_ext;
    logic [MAX_NREQ-1:0]     ready_ext;
    logic                    out_free;
    logic                    gnt_valid;
    logic                    gnt_last;
    logic [7:0]              gnt_data;
    logic                    hs;
    logic                    load;
    logic [7:0]              load_byte;
    logic [ID_W-1:0]         pick_idx;
    logic                    pick_any;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
        return (g == ID_W'(NREQ - 1)) ? '0 : g + ID_W'(1);
    endfunction

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Widen the requester buses to the family maximum so grant_id can index
    // them directly regardless of NREQ.
    assign valid_ext = MAX_NREQ'(req_valid);
    assign last_ext  = MAX_NREQ'(req_last);
    assign data_ext  = (8*MAX_NREQ)'(req_data);

    assign out_free  = !out_valid || out_ready;
    assign gnt_valid = valid_ext[grant_id];
    assign gnt_last  = last_ext[grant_id];
    assign gnt_data  = data_ext[{grant_id, 3'b000} +: 8];
    assign hs        = (state == ST_DATA) && gnt_valid && out_free;

    assign load      = ((state == ST_TAG) && out_free) || hs;
    assign load_byte = (state == ST_TAG) ? tag_byte(grant_id) : gnt_data;

    assign ready_ext = ((state == ST_DATA) && out_free) ? (MAX_NREQ'(1) << grant_id) : '0;
    assign req_ready = ready_ext[NREQ-1:0];
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            grant_id    <= '0;
            rr_ptr      <= '0;
            idle_cnt    <= '0;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;

            // Output stage: a load wins over a drain so back-to-back bytes
            // flow at one per cycle; the byte is held while the sink stalls.
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_byte;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        if (TAG_EN != 0) begin
                            state <= ST_TAG;
                        end else begin
                            state    <= ST_DATA;
                            idle_cnt <= '0;
                        end
                    end
                end

                ST_TAG: begin
                    if (out_free) begin
                        state    <= ST_DATA;
                        idle_cnt <= '0;
                    end
                end

                ST_DATA: begin
                    if (hs) begin
                        idle_cnt <= '0;
                        if (gnt_last) begin
                            state  <= ST_IDLE;
                            rr_ptr <= next_ptr(grant_id);
                        end
                    end else if (!gnt_valid) begin
                        // Only cycles with nothing offered count as idle;
                        // a grantee stalled by the sink keeps its grant.
                        if (idle_cnt == TO_LAST) begin
                            timeout_evt <= 1'b1;
                            state       <= ST_IDLE;
                            rr_ptr      <= next_ptr(grant_id);
                        end else begin
                            idle_cnt <= idle_cnt + CNT_W'(1);
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter. dut_a: NREQ=4, TIMEOUT=4, TAG_EN=1.
// dut_b: NREQ=4, TIMEOUT=255, TAG_EN=0 (full-throughput packet).
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        out_valid, out_ready, busy, timeout_evt;
    logic [7:0]  out_data;
    logic [2:0]  grant_id;

    logic [3:0]  b_req_valid, b_req_last, b_req_ready;
    logic [31:0] b_req_data;
    logic        b_out_valid, b_out_ready, b_busy, b_timeout_evt;
    logic [7:0]  b_out_data;
    logic [2:0]  b_grant_id;

    uart_tx_arbiter #(.NREQ(4), .TIMEOUT(4), .TAG_EN(1)) dut_a (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .grant_id(grant_id),
        .busy(busy), .timeout_evt(timeout_evt)
    );

    uart_tx_arbiter #(.NREQ(4), .TIMEOUT(255), .TAG_EN(0)) dut_b (
        .clk(clk), .rstn(rstn), .req_valid(b_req_valid), .req_data(b_req_data),
        .req_last(b_req_last), .req_ready(b_req_ready), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_ready(b_out_ready), .grant_id(b_grant_id),
        .busy(b_busy), .timeout_evt(b_timeout_evt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] tag;
        logic [2:0] ptr;
    } row_t;
    row_t rows[4];

    // Requester model: per-requester byte queue with end-of-packet flags.
    logic [7:0] q[4][$];
    bit         lq[4][$];
    int         gap[4];
    int         max_gap = 0;
    int         ready_pct = 100;
    logic [7:0] obs[$];
    logic [7:0] exp_q[$];
    int         to_cnt = 0;
    int         oh_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            lq[i].delete();
            gap[i] = 0;
        end
    endtask

    task automatic push_byte(input int id, input logic [7:0] b, input bit last);
        q[id].push_back(b);
        lq[id].push_back(last);
    endtask

    // One clock of dut_a: drive requesters and sink, then record transfers.
    task automatic tick_a();
        bit l;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0 && gap[i] == 0) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = q[i][0];
                req_last[i]       = lq[i][0];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
        out_ready = ($urandom_range(99) < 32'(ready_pct));
        #1;
        if (out_valid && out_ready) obs.push_back(out_data);
        if (timeout_evt) to_cnt++;
        if ($countones(req_ready) > 1) oh_bad++;
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                void'(q[i].pop_front());
                l = lq[i].pop_front();
                gap[i] = (!l && max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
            end else if (gap[i] > 0) begin
                gap[i]--;
            end
        end
    endtask

    task automatic run_until(input int n, input int budget);
        for (int c = 0; c < budget && obs.size() < n; c++) tick_a();
    endtask

    // Reference: packets served whole, in round-robin order over the
    // requesters that still have packets, each prefixed by A0|id.
    task automatic build_expected(input int ptr);
        logic [7:0] mq[4][$];
        bit         ml[4][$];
        int         p, id;
        bit         found, l;
        p = ptr;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            mq[i] = q[i];
            ml[i] = lq[i];
        end
        while (1) begin
            found = 1'b0;
            id    = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && mq[(p + k) % 4].size() > 0) begin
                    found = 1'b1;
                    id    = (p + k) % 4;
                end
            end
            if (!found) break;
            exp_q.push_back(8'hA0 | 8'(id));
            l = 1'b0;
            while (!l && mq[id].size() > 0) begin
                exp_q.push_back(mq[id].pop_front());
                l = ml[id].pop_front();
            end
            p = (id + 1) % 4;
        end
    endtask

    task automatic compare_obs(input string name);
        check({name, "_count"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), 32'(obs[i]), 32'(exp_q[i]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        flush();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         id;
        logic [3:0] sel;
        logic [7:0] pkt[16];
        int         idx, oidx, first_hs, first_out, last_out;
        int         npk, len;

        rows[0] = '{2, 8'h48, 8'h69, 8'hA2, 3'd3};
        rows[1] = '{3, 8'h3C, 8'hC3, 8'hA3, 3'd0};
        rows[2] = '{0, 8'h00, 8'hFF, 8'hA0, 3'd1};
        rows[3] = '{1, 8'h5A, 8'hA5, 8'hA1, 3'd2};

        rstn = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        b_req_valid = '0; b_req_last = '0; b_req_data = '0; b_out_ready = 1'b0;
        flush();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_evt", 32'(timeout_evt), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rr_ptr", 32'(dut_a.rr_ptr), 32'd0);
        check("rst_idle_cnt", 32'(dut_a.idle_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Single two-byte packets, cycle-accurate
        for (int r = 0; r < 4; r++) begin
            id  = rows[r].id;
            sel = 4'(1 << id);
            @(negedge clk);
            req_valid = sel; req_data = 32'(rows[r].b0) << (8*id); req_last = '0; out_ready = 1'b1;
            #1;
            check($sformatf("tbl%0d_idle_busy", r), 32'(busy), 32'd0);
            @(negedge clk); #1;
            check($sformatf("tbl%0d_grant_busy", r), 32'(busy), 32'd1);
            check($sformatf("tbl%0d_grant_id", r), 32'(grant_id), 32'(id));
            check($sformatf("tbl%0d_tagcyc_ready", r), 32'(req_ready), 32'd0);
            @(negedge clk); #1;
            check($sformatf("tbl%0d_tag_valid", r), 32'(out_valid), 32'd1);
            check($sformatf("tbl%0d_tag_data", r), 32'(out_data), 32'(rows[r].tag));
            check($sformatf("tbl%0d_hs0_ready", r), 32'(req_ready), 32'(sel));
            @(negedge clk);
            req_data = 32'(rows[r].b1) << (8*id); req_last = sel;
            #1;
            check($sformatf("tbl%0d_b0_data", r), 32'(out_data), 32'(rows[r].b0));
            check($sformatf("tbl%0d_hs1_ready", r), 32'(req_ready), 32'(sel));
            @(negedge clk);
            req_valid = '0; req_last = '0; req_data = '0;
            #1;
            check($sformatf("tbl%0d_b1_data", r), 32'(out_data), 32'(rows[r].b1));
            check($sformatf("tbl%0d_end_busy", r), 32'(busy), 32'd0);
            check($sformatf("tbl%0d_rr_ptr", r), 32'(dut_a.rr_ptr), 32'(rows[r].ptr));
            @(negedge clk); #1;
            check($sformatf("tbl%0d_drain", r), 32'(out_valid), 32'd0);
        end

        // Round robin between requesters 0 and 1
        flush(); obs.delete(); ready_pct = 100; max_gap = 0;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            push_byte(0, 8'h10, 1'b1);
            push_byte(1, 8'h20, 1'b1);
            exp_q.push_back(8'hA0); exp_q.push_back(8'h10);
            exp_q.push_back(8'hA1); exp_q.push_back(8'h20);
        end
        run_until(16, 100);
        compare_obs("rr");

        // Backpressure for 5 cycles mid-packet
        flush(); obs.delete(); ready_pct = 100;
        push_byte(0, 8'hC1, 1'b0); push_byte(0, 8'hC2, 1'b0);
        push_byte(0, 8'hC3, 1'b0); push_byte(0, 8'hC4, 1'b1);
        run_until(2, 20);
        ready_pct = 0;
        for (int s = 0; s < 5; s++) begin
            tick_a();
            check($sformatf("bp%0d_valid", s), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_data", s), 32'(out_data), 32'hC2);
            check($sformatf("bp%0d_ready", s), 32'(req_ready), 32'd0);
            check($sformatf("bp%0d_idle_cnt", s), 32'(dut_a.idle_cnt), 32'd0);
        end
        ready_pct = 100;
        run_until(5, 20);
        exp_q.delete();
        exp_q.push_back(8'hA0); exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
        exp_q.push_back(8'hC3); exp_q.push_back(8'hC4);
        compare_obs("bp");

        // Timeout: requester 1 stalls mid-packet, requester 3 is waiting
        flush(); obs.delete(); ready_pct = 100; to_cnt = 0;
        push_byte(1, 8'h55, 1'b0);
        push_byte(3, 8'h77, 1'b1);
        for (int c = 0; c < 20 && q[1].size() > 0; c++) tick_a();
        check("to_first_hs", 32'(q[1].size()), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick_a();
            check($sformatf("to_evt_k%0d", k), 32'(timeout_evt), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) check("to_busy_low", 32'(busy), 32'd0);
            if (k == 6) check("to_next_grant", 32'(grant_id), 32'd3);
        end
        run_until(4, 20);
        check("to_pulses", 32'(to_cnt), 32'd1);
        exp_q.delete();
        exp_q.push_back(8'hA1); exp_q.push_back(8'h55);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h77);
        compare_obs("to");

        // TAG_EN=0, 16-byte packet at full rate on dut_b
        for (int i = 0; i < 16; i++) pkt[i] = 8'(i * 17 + 3);
        idx = 0; oidx = 0; first_hs = -1; first_out = -1; last_out = -1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            b_req_valid = (idx < 16) ? 4'b0100 : 4'b0000;
            b_req_data  = (idx < 16) ? (32'(pkt[idx]) << 16) : 32'd0;
            b_req_last  = (idx == 15) ? 4'b0100 : 4'b0000;
            b_out_ready = 1'b1;
            #1;
            if (b_out_valid) begin
                if (first_out < 0) first_out = c;
                last_out = c;
                if (oidx < 16) check($sformatf("tput_byte%0d", oidx), 32'(b_out_data), 32'(pkt[oidx]));
                oidx++;
            end
            if (b_req_valid[2] && b_req_ready[2]) begin
                if (first_hs < 0) first_hs = c;
                idx++;
            end
        end
        b_req_valid = '0; b_req_last = '0; b_req_data = '0;
        check("tput_count", 32'(oidx), 32'd16);
        check("tput_span", 32'(last_out - first_out), 32'd15);
        check("tput_first_hs", 32'(first_hs), 32'd1);

        // Reset mid-packet
        flush(); obs.delete(); ready_pct = 100;
        for (int i = 0; i < 6; i++) push_byte(2, 8'hD0 + 8'(i), i == 5);
        for (int c = 0; c < 30 && q[2].size() > 4; c++) tick_a();
        rstn = 1'b0;
        tick_a();
        @(negedge clk);
        rstn = 1'b1;
        flush();
        req_valid = '0; req_last = '0; req_data = '0;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_req_ready", 32'(req_ready), 32'd0);
        check("mrst_grant_id", 32'(grant_id), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        obs.delete();
        push_byte(2, 8'hE0, 1'b0); push_byte(2, 8'hE1, 1'b1);
        run_until(3, 20);
        exp_q.delete();
        exp_q.push_back(8'hA2); exp_q.push_back(8'hE0); exp_q.push_back(8'hE1);
        compare_obs("mrst");

        // Randomized packets, gaps and sink backpressure vs reference
        for (int r = 0; r < 3; r++) begin
            do_reset();
            obs.delete();
            for (int i = 0; i < 4; i++) begin
                npk = int'($urandom_range(3));
                for (int p = 0; p < npk; p++) begin
                    len = int'($urandom_range(6, 1));
                    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
                end
            end
            build_expected(0);
            ready_pct = 70; max_gap = 3; to_cnt = 0; oh_bad = 0;
            run_until(exp_q.size(), 3000);
            compare_obs($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_timeouts", r), 32'(to_cnt), 32'd0);
            check($sformatf("rnd%0d_onehot", r), 32'(oh_bad), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares the single JTAG UART transmit byte channel among up to 8 on-chip requesters (CPU console, debug log, trace, …). Each requester presents a byte stream framed by a `last` flag. The arbiter grants one requester per packet, optionally prefixes a channel-tag byte, and forwards the bytes through a registered valid/ready output into the JTAG UART TX FIFO write port. A stalled requester is dropped after a programmable idle timeout, so one channel cannot wedge the link.

## Interface
Parameters:
- `NREQ`, default 4 — number of requesters, legal range 2..8.
- `TIMEOUT`, default 255 — consecutive cycles with the granted `req_valid` low before the grant is revoked; legal range 1..65535.
- `TAG_EN`, default 1 — when 1, emit tag byte `{4'hA, 1'b0, id[2:0]}` before each packet.

Ports:
- `clk` — in, 1 — clock.
- `rstn` — in, 1 — reset, synchronous, active-low.
- `req_valid` — in, NREQ — per-requester byte valid.
- `req_data` — in, 8*NREQ — requester i occupies bits [8i+7:8i].
- `req_last` — in, NREQ — byte is the final byte of the packet.
- `req_ready` — out, NREQ — per-requester accept; at most one bit set.
- `out_valid` — out, 1 — output byte valid (registered).
- `out_data` — out, 8 — output byte (registered).
- `out_ready` — in, 1 — sink accepts the byte; sink is the TX FIFO not-full.
- `grant_id` — out, 3 — index of the current or most recent grantee.
- `busy` — out, 1 — state ≠ IDLE.
- `timeout_evt` — out, 1 — one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, TAG, DATA.
- **IDLE**
  - If any `req_valid` is set, pick the first set bit scanning upward from `rr_ptr` with wrap-around.
  - Register the winner into `grant_id`.
  - Go to TAG if `TAG_EN`=1, otherwise to DATA.
  - `req_valid` is sampled only in IDLE; requests arriving mid-packet wait.
- **TAG**
  - When the output register is free (`!out_valid || out_ready`), load the tag byte and go to DATA.
- **DATA**
  - `req_ready[grant_id] = (!out_valid || out_ready)`; all other `req_ready` bits are 0.
  - On a handshake (`req_valid & req_ready` of the grantee), load the byte into `out_data` and set `out_valid`.
  - If `req_last` is set on that handshake, go to IDLE and set `rr_ptr = grant_id+1` (mod NREQ).
- **Timeout**
  - `idle_cnt` (16 bit) clears on entry to DATA and on every grantee handshake.
  - It increments on each DATA cycle in which the grantee's `req_valid`=0.
  - Cycles where `req_valid`=1 but the output is blocked do not count.
  - When `idle_cnt` reaches `TIMEOUT-1` while `req_valid` is still 0: pulse `timeout_evt`, go to IDLE, set `rr_ptr = grant_id+1`.
  - No terminator byte is inserted on timeout.
- **Output register**
  - `out_valid` clears on `out_ready` when no new byte loads that cycle.
  - Load and drain in the same cycle sustain 1 byte/cycle.
  - `out_data` is stable while `out_valid && !out_ready`.
- **Reset values:** `out_valid`=0, `out_data`=8'h00, `grant_id`=0, `busy`=0, `timeout_evt`=0, `req_ready`=0, `rr_ptr`=0, state IDLE, `idle_cnt`=0.
- Reset mid-packet discards the packet state and any held output byte. The requester sees `req_ready`=0 from the next cycle.

## Timing
- Request seen in IDLE at cycle n:
  - `grant_id` valid and `busy`=1 at n+1.
  - With `TAG_EN`=1 and a free sink: tag byte on `out_valid` at n+2, first data handshake at n+2, first data byte on output at n+3.
  - With `TAG_EN`=0: first handshake at n+1.
- Last-byte handshake at cycle m: IDLE at m+1; the next grant is registered at m+2. The per-packet overhead is 1 cycle, plus 1 more with tag.
- Timeout: `timeout_evt` is high in the cycle after the `TIMEOUT`-th consecutive idle cycle. IDLE is entered in that same cycle.
- All outputs are registered except `req_ready`, which decodes state, `grant_id`, `out_valid` and `out_ready`.

## Structure
- Package `uart_arb_pkg`:
  - state enum (IDLE/TAG/DATA)
  - `TAG_PREFIX`=4'hA
  - `MAX_NREQ`=8
  - `CNT_W`=16
- Sub-module `rr_picker`: combinational. Inputs are `req[NREQ]` and `ptr`; outputs are `idx` and `any`. It is reused by future arbiters.
- The top holds the FSM, output register, `idle_cnt` and `rr_ptr`.

## Test plan
- **Single packet:** requester 2 sends 0x48,0x69 (last), `out_ready`=1 → output A2,48,69; `rr_ptr`=3; `busy` low one cycle after the last handshake.
- **Round robin:** requesters 0 and 1 continuously send 1-byte packets, with 0x10 from requester 0 and 0x20 from requester 1 → output A0,10,A1,20,A0,10…; no starvation.
- **Backpressure:** hold `out_ready`=0 for 5 cycles mid-packet → `out_data` holds; `req_ready`=0; no byte is lost or duplicated; `idle_cnt` does not advance.
- **Timeout:** `TIMEOUT`=4; requester 1 sends 0x55 (not last) then deasserts valid → `timeout_evt` pulses exactly once after 4 idle cycles; requester 3 (pending) is granted next with tag A3.
- **TAG_EN=0, full throughput:** 16-byte packet with `out_ready`=1 → 16 consecutive output cycles, bytes in order.
- **Reset mid-packet:** assert `rstn`=0 during byte 3 → next cycle `out_valid`=0, `req_ready`=0, `grant_id`=0; after release, a new packet starts with its tag.
